demux4_buf: RTL and testbench
=============================

Name: demux4_buf

Overview:
- 1-to-4 registered demultiplexer with per-output valid/ready handshake; the distributing counterpart of the datapath select muxes.
- Takes one upstream word plus a 2-bit destination select and delivers it to exactly one of four downstream channels.
- Each channel has a one-entry output register, so a stalled consumer blocks only traffic addressed to it.
- Used on the memory/cache side to route responses or write data back to one of up to four requesters.

Parameters:
- width, 16, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_sel  input  2  destination channel index (0..3); sampled only when in_valid=1.
- in_data  input  width  upstream word.
- in_ready  output  1  block can accept the word addressed by in_sel this cycle.
- out_valid  output  4  bit i = channel i holds a word.
- out_ready  input  4  bit i = channel i consumer accepts this cycle.
- out_data0  output  width  channel 0 word.
- out_data1  output  width  channel 1 word.
- out_data2  output  width  channel 2 word.
- out_data3  output  width  channel 3 word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=4'b0000 and all out_dataN=0, applied immediately on rst assertion. While rst=1, in_ready=0. Reset mid-transfer discards any buffered words.
- Per-channel state: valid flag v[i] and data register d[i]. out_valid[i]=v[i]; out_dataN=d[N]. No other state.
- in_ready is combinational: ~v[in_sel] | out_ready[in_sel]. It depends only on in_sel, v and out_ready, never on in_valid.
- Accept: acc = in_valid & in_ready. On acc, d[in_sel] <= in_data and v[in_sel] <= 1.
- Drain: channel i drains when v[i] & out_ready[i].
- Simultaneous fill and drain on the same channel: v[i] stays 1 and d[i] takes the new word. This gives full throughput of 1 word/cycle per channel.
- Drain without fill: v[i] <= 0 and d[i] holds its stale value.
- Channels are independent: any subset may drain in the same cycle as a fill to another channel.
- Latency: a word accepted in cycle t appears at out_valid/out_dataN in cycle t+1. There is no combinational in_data to out_data path.
- Stall rule: once v[i]=1, d[i] and v[i] hold until the drain handshake. A producer must hold in_sel and in_data stable while in_valid=1 and in_ready=0.
- out_ready[i] while v[i]=0 has no effect.
- Ordering: per-channel FIFO order with depth 1. Words are never dropped or duplicated.

Optional Feature:
- Macro: DEMUX4_COUNT_EN.
- Defined:
  - Adds output port xfer_count, 32 bits, made of four 8-bit fields; bits [8i+7:8i] = channel i.
  - Each field counts completed drain handshakes on its channel.
  - Increments by 1 per drain and wraps 255 -> 0.
  - All fields reset to 0 on rst.
- Undefined: no port, no counters. Datapath behaviour is identical in both cases.

Test Plan:
- Reset: assert rst mid-stream with v=4'b1010 -> out_valid=0 and all out_dataN=0 immediately (before the next clk edge); in_ready=0 while rst=1.
- Basic route: in_valid=1, in_sel=2, in_data=16'hBEEF, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=16'hBEEF; out_data0/1/3 unchanged.
- Backpressure: channel 1 full with 16'h1111, out_ready[1]=0, offer 16'h2222 to sel=1 -> in_ready=0 and out_data1 stays 16'h1111 for 5 cycles; raise out_ready[1] -> 16'h2222 appears next cycle.
- Throughput: out_ready=4'b1111, stream 16'h0001..16'h0008 to sel=3 every cycle -> in_ready stays 1 and channel 3 emits 8 words on 8 consecutive cycles, in order.
- Independence: channel 0 stalled full, then send 16'hA0A0 to sel=2 -> accepted (in_ready=1); out_valid=4'b0101 next cycle.
- Counter (DEMUX4_COUNT_EN defined): 257 drains on channel 3 -> xfer_count[31:24]=8'd1 and all other fields 0.

Source files
------------

// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 registered demux, one output register per channel.
// Define DEMUX4_COUNT_EN to add per-channel drain counters on xfer_count.
module demux4_buf #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [width-1:0] out_data0,
  output logic [width-1:0] out_data1,
  output logic [width-1:0] out_data2,
`ifdef DEMUX4_COUNT_EN
  output logic [width-1:0] out_data3,
  output logic [31:0]      xfer_count
`else
  output logic [width-1:0] out_data3
`endif
);

  logic [3:0]       v;
  logic [width-1:0] d [4];
  logic             acc;
  logic [3:0]       fill;
  logic [3:0]       drain;

  // A slot can take a word if empty or if it is draining this cycle
  assign in_ready = ~rst & (~v[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;
  assign fill     = acc ? (4'b0001 << in_sel) : 4'b0000;
  assign drain    = v & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 4'b0000;
      for (int i = 0; i < 4; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fill[i]) d[i] <= in_data;
        v[i] <= fill[i] | (v[i] & ~drain[i]);
      end
    end
  end

  assign out_valid = v;
  assign out_data0 = d[0];
  assign out_data1 = d[1];
  assign out_data2 = d[2];
  assign out_data3 = d[3];

`ifdef DEMUX4_COUNT_EN
  logic [7:0] cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (drain[i]) cnt[i] <= cnt[i] + 8'd1;
    end
  end

  assign xfer_count = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: directed-vector bench for demux4_buf.
// Build with DEMUX4_COUNT_EN defined to also check xfer_count.
module tb_demux4_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_sel;
  logic [15:0] in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data0;
  logic [15:0] out_data1;
  logic [15:0] out_data2;
  logic [15:0] out_data3;
`ifdef DEMUX4_COUNT_EN
  logic [31:0] xfer_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  demux4_buf #(.width(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
`ifdef DEMUX4_COUNT_EN
    .out_data3 (out_data3),
    .xfer_count(xfer_count)
`else
    .out_data3 (out_data3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 16'h0;
    out_ready = 4'b0000;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(in_ready), 32'd1);

    // basic route to channel 2
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 16'hBEEF;
    #1;
    chk("route_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("route_valid", 32'(out_valid), 32'b0100);
    chk("route_d2", 32'(out_data2), 32'hBEEF);
    chk("route_d0", 32'(out_data0), 32'h0);
    chk("route_d1", 32'(out_data1), 32'h0);
    chk("route_d3", 32'(out_data3), 32'h0);

    // backpressure on channel 1
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 16'h1111;
    tick();
    in_data = 16'h2222;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_hold", 32'(out_data1), 32'h1111);
      chk("bp_valid", 32'(out_valid), 32'b0110);
    end
    out_ready = 4'b0010;
    #1;
    chk("bp_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_new", 32'(out_data1), 32'h2222);
    chk("bp_valid2", 32'(out_valid), 32'b0110);
    tick();
    out_ready = 4'b0000;
    chk("bp_drained", 32'(out_valid), 32'b0100);
    chk("bp_stale", 32'(out_data1), 32'h2222);

    // independence: ch0 stalled, ch2 still accepts
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("ind_empty", 32'(out_valid), 32'b0000);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 16'h00C0;
    tick();
    in_sel  = 2'd2;
    in_data = 16'hA0A0;
    #1;
    chk("ind_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("ind_valid", 32'(out_valid), 32'b0101);
    chk("ind_d2", 32'(out_data2), 32'hA0A0);
    chk("ind_d0", 32'(out_data0), 32'h00C0);

    // full-rate stream to channel 3
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    for (int k = 1; k <= 8; k++) begin
      in_data = 16'(k);
      #1;
      chk("tp_ready", 32'(in_ready), 32'd1);
      tick();
      chk("tp_valid", 32'(out_valid), 32'b1000);
      chk("tp_d3", 32'(out_data3), 32'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("tp_empty", 32'(out_valid), 32'b0000);

    // async reset with v = 4'b1010
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 16'h5151;
    tick();
    in_sel  = 2'd3;
    in_data = 16'h7373;
    tick();
    in_valid = 1'b0;
    in_sel   = 2'd1;
    chk("pre_rst_v", 32'(out_valid), 32'b1010);
    chk("pre_rst_d1", 32'(out_data1), 32'h5151);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_d1", 32'(out_data1), 32'h0);
    chk("arst_d3", 32'(out_data3), 32'h0);
    chk("arst_d2", 32'(out_data2), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
`ifdef DEMUX4_COUNT_EN
    chk("cnt_rst", xfer_count, 32'h0);
`endif

    // 257 drains on channel 3
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    for (int k = 1; k <= 257; k++) begin
      in_data = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    chk("wrap_valid", 32'(out_valid), 32'd0);
    chk("wrap_d3", 32'(out_data3), 32'd257);
`ifdef DEMUX4_COUNT_EN
    chk("cnt_wrap", xfer_count, 32'h0100_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
